palette_bank_dbuf: RTL and testbench

//  Parametrised, runtime-writable sprite colour palette: NUM_PAL palettes of 2**IDX_W entries, each entry RGB (3*COLOR_W bits).

---
 rtl/palette_pkg.sv | 36 +++
 rtl/palette_lookup_ch.sv | 91 +++++++++
 rtl/palette_bank_dbuf.sv | 112 +++++++++++
 tb/tb_palette_bank_dbuf.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared types, the power-on colour table and the fade helper
// for the double-buffered sprite palette (palette_bank_dbuf).
package palette_pkg;

  localparam int DEF_COLOR_W = 4;
  localparam int DEF_ENTRIES = 16;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // Classic 16-colour table, replicated into every palette at reset
  localparam rgb_t DEFAULT_PALETTE [DEF_ENTRIES] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  // Default colour for an entry; indices beyond the table wrap around it
  function automatic logic [3*DEF_COLOR_W-1:0] default_rgb(input int unsigned idx);
    return DEFAULT_PALETTE[idx % DEF_ENTRIES];
  endfunction

  // Scale one component by a fade level: (c * lvl) >> w, truncated
  function automatic logic [15:0] fade_comp(input logic [15:0] c,
                                            input logic [15:0] lvl,
                                            input int unsigned w);
    logic [31:0] prod;
    prod = 32'(c) * 32'(lvl);
    return 16'(prod >> w);
  endfunction

endpackage

// File: rtl/palette_lookup_ch.sv
// palette_lookup_ch: one registered lookup channel. Registers the looked-up
// colour, flags the transparent index and, when PALETTE_FADE_EN is defined,
// adds a second stage that applies the fade level.
module palette_lookup_ch
  import palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int COLOR_W    = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_valid,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [3*COLOR_W-1:0] lookup_rgb,
`ifdef PALETTE_FADE_EN
  input  logic [COLOR_W-1:0]   fade_lvl,
`endif
  output logic                 rgb_valid,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 transparent
);

  logic is_transp;
  assign is_transp = (rd_idx == IDX_W'(TRANSP_IDX));

`ifdef PALETTE_FADE_EN
  logic                 s1_valid;
  logic                 s1_transp;
  logic [3*COLOR_W-1:0] s1_rgb;
  logic [COLOR_W-1:0]   s1_lvl;

  // Stage 1: capture the raw colour and fade level; hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_rgb    <= '0;
      s1_lvl    <= '0;
    end else begin
      s1_valid <= rd_valid;
      if (rd_valid) begin
        s1_transp <= is_transp;
        s1_rgb    <= lookup_rgb;
        s1_lvl    <= fade_lvl;
      end
    end
  end

  // Stage 2: scale each component by the captured fade level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      rgb_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= s1_transp;
        red   <= COLOR_W'(fade_comp(16'(s1_rgb[3*COLOR_W-1 -: COLOR_W]), 16'(s1_lvl), COLOR_W));
        green <= COLOR_W'(fade_comp(16'(s1_rgb[2*COLOR_W-1 -: COLOR_W]), 16'(s1_lvl), COLOR_W));
        blue  <= COLOR_W'(fade_comp(16'(s1_rgb[COLOR_W-1:0]), 16'(s1_lvl), COLOR_W));
      end
    end
  end
`else
  // Single stage: register the colour as-is; hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      rgb_valid <= rd_valid;
      if (rd_valid) begin
        transparent <= is_transp;
        red         <= lookup_rgb[3*COLOR_W-1 -: COLOR_W];
        green       <= lookup_rgb[2*COLOR_W-1 -: COLOR_W];
        blue        <= lookup_rgb[COLOR_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/palette_bank_dbuf.sv
// palette_bank_dbuf: double-buffered, runtime-writable sprite palette bank.
// Writes land in a back copy; a commit copies back to front at the next
// frame_start so colours never change mid-frame. N_CH independent lookup
// channels read the front copy. Optional feature macro: PALETTE_FADE_EN
// (adds fade_lvl input and a second lookup stage).
module palette_bank_dbuf
  import palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int COLOR_W    = 4,
  parameter int NUM_PAL    = 4,
  parameter int N_CH       = 2,
  parameter int TRANSP_IDX = 0,
  localparam int PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int ENTRIES   = 2 ** IDX_W
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    wr_en,
  input  logic [PAL_W-1:0]        wr_pal,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [3*COLOR_W-1:0]    wr_rgb,
  input  logic                    commit,
  input  logic                    frame_start,
  output logic                    swap_pending,
  input  logic [N_CH-1:0]         rd_valid,
  input  logic [N_CH*PAL_W-1:0]   rd_pal,
  input  logic [N_CH*IDX_W-1:0]   rd_idx,
`ifdef PALETTE_FADE_EN
  input  logic [COLOR_W-1:0]      fade_lvl,
`endif
  output logic [N_CH-1:0]         rgb_valid,
  output logic [N_CH*COLOR_W-1:0] red,
  output logic [N_CH*COLOR_W-1:0] green,
  output logic [N_CH*COLOR_W-1:0] blue,
  output logic [N_CH-1:0]         transparent
);

  logic [3*COLOR_W-1:0] front [NUM_PAL][ENTRIES];
  logic [3*COLOR_W-1:0] back  [NUM_PAL][ENTRIES];
  logic                 do_swap;
  logic                 wr_ok;

  // Widen/narrow each 4-bit default component to COLOR_W
  function automatic logic [3*COLOR_W-1:0] def_entry(input int unsigned e);
    logic [11:0] d;
    d = default_rgb(e);
    return {COLOR_W'(d[11:8]), COLOR_W'(d[7:4]), COLOR_W'(d[3:0])};
  endfunction

  assign do_swap = frame_start && (swap_pending || commit);
  assign wr_ok   = wr_en && (int'(wr_pal) < NUM_PAL);

  // Storage and commit: swap copies pre-edge back contents, a concurrent write lands in back only
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      swap_pending <= 1'b0;
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          front[p][e] <= def_entry(e);
          back[p][e]  <= def_entry(e);
        end
      end
    end else begin
      if (do_swap) begin
        front <= back;
      end
      if (wr_ok) begin
        back[wr_pal][wr_idx] <= wr_rgb;
      end
      swap_pending <= do_swap ? 1'b0 : (swap_pending | commit);
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [PAL_W-1:0]     ch_pal;
    logic [IDX_W-1:0]     ch_idx;
    logic [3*COLOR_W-1:0] ch_rgb;

    assign ch_pal = rd_pal[ch*PAL_W +: PAL_W];
    assign ch_idx = rd_idx[ch*IDX_W +: IDX_W];

    // Read the front copy; a nonexistent palette reads as black
    always_comb begin
      ch_rgb = '0;
      if (int'(ch_pal) < NUM_PAL) begin
        ch_rgb = front[ch_pal][ch_idx];
      end
    end

    palette_lookup_ch #(
      .IDX_W      (IDX_W),
      .COLOR_W    (COLOR_W),
      .TRANSP_IDX (TRANSP_IDX)
    ) u_ch (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .rd_valid    (rd_valid[ch]),
      .rd_idx      (ch_idx),
      .lookup_rgb  (ch_rgb),
`ifdef PALETTE_FADE_EN
      .fade_lvl    (fade_lvl),
`endif
      .rgb_valid   (rgb_valid[ch]),
      .red         (red[ch*COLOR_W +: COLOR_W]),
      .green       (green[ch*COLOR_W +: COLOR_W]),
      .blue        (blue[ch*COLOR_W +: COLOR_W]),
      .transparent (transparent[ch])
    );
  end

endmodule

// File: tb/tb_palette_bank_dbuf.sv
// tb_palette_bank_dbuf: self-checking bench for palette_bank_dbuf (default
// build, 1-cycle lookup). A behavioural palette model tracks front/back
// copies and the pending commit and predicts every channel result.
module tb_palette_bank_dbuf;

  localparam int IDX_W = 4, COLOR_W = 4, NUM_PAL = 4, N_CH = 2, TRANSP_IDX = 0;
  localparam int PAL_W = 2;

  logic                    Clk = 1'b0;
  logic                    Reset_n;
  logic                    wr_en;
  logic [PAL_W-1:0]        wr_pal;
  logic [IDX_W-1:0]        wr_idx;
  logic [3*COLOR_W-1:0]    wr_rgb;
  logic                    commit;
  logic                    frame_start;
  logic                    swap_pending;
  logic [N_CH-1:0]         rd_valid;
  logic [N_CH*PAL_W-1:0]   rd_pal;
  logic [N_CH*IDX_W-1:0]   rd_idx;
  logic [N_CH-1:0]         rgb_valid;
  logic [N_CH*COLOR_W-1:0] red, green, blue;
  logic [N_CH-1:0]         transparent;

  int tests = 0;
  int fails = 0;

  logic [11:0] def_tab [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF };

  logic [11:0] front_m [NUM_PAL][16];
  logic [11:0] back_m  [NUM_PAL][16];
  logic        pend_m;
  logic [11:0] exp_rgb [N_CH];
  logic        exp_v   [N_CH];
  logic        exp_t   [N_CH];

  palette_bank_dbuf dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .wr_en        (wr_en),
    .wr_pal       (wr_pal),
    .wr_idx       (wr_idx),
    .wr_rgb       (wr_rgb),
    .commit       (commit),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .rd_valid     (rd_valid),
    .rd_pal       (rd_pal),
    .rd_idx       (rd_idx),
    .rgb_valid    (rgb_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .transparent  (transparent)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] dut_rgb(input int ch);
    return {red[ch*4 +: 4], green[ch*4 +: 4], blue[ch*4 +: 4]};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NUM_PAL; p++)
      for (int e = 0; e < 16; e++) begin
        front_m[p][e] = def_tab[e];
        back_m[p][e]  = def_tab[e];
      end
    pend_m = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      exp_rgb[c] = '0; exp_v[c] = 1'b0; exp_t[c] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_pal = 0; wr_idx = 0; wr_rgb = 0;
    commit = 0; frame_start = 0; rd_valid = 0; rd_pal = 0; rd_idx = 0;
  endtask

  // Apply the palette rules for the current inputs, then advance one clock
  task automatic tick();
    logic swap;
    int   p, i;
    for (int c = 0; c < N_CH; c++) begin
      exp_v[c] = rd_valid[c];
      if (rd_valid[c]) begin
        p = int'(rd_pal[c*PAL_W +: PAL_W]);
        i = int'(rd_idx[c*IDX_W +: IDX_W]);
        exp_rgb[c] = (p < NUM_PAL) ? front_m[p][i] : 12'h000;
        exp_t[c]   = (i == TRANSP_IDX);
      end
    end
    swap = frame_start && (pend_m || commit);
    if (swap) front_m = back_m;
    if (wr_en && int'(wr_pal) < NUM_PAL) back_m[wr_pal][wr_idx] = wr_rgb;
    pend_m = swap ? 1'b0 : (pend_m | commit);
    @(posedge Clk);
    #1;
  endtask

  task automatic read1(input int ch, input int pal, input int idx);
    idle();
    rd_valid[ch] = 1'b1;
    rd_pal[ch*PAL_W +: PAL_W] = PAL_W'(pal);
    rd_idx[ch*IDX_W +: IDX_W] = IDX_W'(idx);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tests++;
    if (rgb_valid !== 2'b00 || red !== 0 || green !== 0 || blue !== 0 ||
        transparent !== 2'b00 || swap_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: valid=%b r=%h g=%h b=%h t=%b sp=%b, want all 0",
               rgb_valid, red, green, blue, transparent, swap_pending);
    end
  endtask

  task automatic test_default_lookup();
    read1(0, 0, 3);
    tests++;
    if (rgb_valid[0] !== 1'b1 || dut_rgb(0) !== 12'h0AA) begin
      fails++;
      $display("[TB] FAIL default_lookup: valid=%b rgb=%h, want 1 0aa", rgb_valid[0], dut_rgb(0));
    end
  endtask

  task automatic test_write_commit();
    idle();
    wr_en = 1; wr_pal = 1; wr_idx = 5; wr_rgb = 12'hF00;
    tick();
    read1(0, 1, 5);
    tests++;
    if (dut_rgb(0) !== def_tab[5]) begin
      fails++;
      $display("[TB] FAIL write_no_commit: rgb=%h, want %h", dut_rgb(0), def_tab[5]);
    end
    idle(); commit = 1; tick();
    tests++;
    if (swap_pending !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pending_set: swap_pending=%b, want 1", swap_pending);
    end
    idle(); commit = 1; tick();
    idle(); frame_start = 1; tick();
    tests++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pending_clear: swap_pending=%b, want 0", swap_pending);
    end
    read1(1, 1, 5);
    tests++;
    if (dut_rgb(1) !== 12'hF00 || rgb_valid[1] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_commit: valid=%b rgb=%h, want 1 f00", rgb_valid[1], dut_rgb(1));
    end
    idle(); frame_start = 1; tick();
    tests++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_frame_start: swap_pending=%b, want 0", swap_pending);
    end
  endtask

  task automatic test_same_cycle_swap();
    idle();
    wr_en = 1; wr_pal = 2; wr_idx = 7; wr_rgb = 12'h0F0; commit = 1; frame_start = 1;
    tick();
    tests++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL same_cycle_pending: swap_pending=%b, want 0", swap_pending);
    end
    read1(0, 2, 7);
    tests++;
    if (dut_rgb(0) !== 12'hAAA) begin
      fails++;
      $display("[TB] FAIL same_cycle_old: rgb=%h, want aaa", dut_rgb(0));
    end
    idle(); commit = 1; frame_start = 1; tick();
    read1(0, 2, 7);
    tests++;
    if (dut_rgb(0) !== 12'h0F0) begin
      fails++;
      $display("[TB] FAIL same_cycle_second: rgb=%h, want 0f0", dut_rgb(0));
    end
  endtask

  task automatic test_transparency();
    idle();
    rd_valid = 2'b11;
    rd_pal = {2'd3, 2'd0};
    rd_idx = {4'd9, 4'(TRANSP_IDX)};
    tick();
    idle();
    tests++;
    if (transparent !== 2'b01 || rgb_valid !== 2'b11 ||
        dut_rgb(0) !== 12'h000 || dut_rgb(1) !== 12'h55F) begin
      fails++;
      $display("[TB] FAIL transparency: t=%b valid=%b rgb0=%h rgb1=%h, want 01 11 000 55f",
               transparent, rgb_valid, dut_rgb(0), dut_rgb(1));
    end
    tick();
    tests++;
    if (rgb_valid !== 2'b00 || transparent !== 2'b01 || dut_rgb(1) !== 12'h55F) begin
      fails++;
      $display("[TB] FAIL hold: valid=%b t=%b rgb1=%h, want 00 01 55f",
               rgb_valid, transparent, dut_rgb(1));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_pal      = PAL_W'($urandom);
      wr_idx      = IDX_W'($urandom);
      wr_rgb      = 12'($urandom);
      commit      = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 9) == 0);
      rd_valid    = N_CH'($urandom);
      rd_pal      = (N_CH*PAL_W)'($urandom);
      rd_idx      = (N_CH*IDX_W)'($urandom);
      tick();
      tests++;
      if (swap_pending !== pend_m) begin
        fails++;
        $display("[TB] FAIL rand_pending cycle %0d: got %b, want %b", n, swap_pending, pend_m);
      end
      for (int c = 0; c < N_CH; c++) begin
        tests++;
        if (rgb_valid[c] !== exp_v[c] || dut_rgb(c) !== exp_rgb[c] || transparent[c] !== exp_t[c]) begin
          fails++;
          $display("[TB] FAIL rand_ch%0d cycle %0d: v=%b rgb=%h t=%b, want v=%b rgb=%h t=%b",
                   c, n, rgb_valid[c], dut_rgb(c), transparent[c], exp_v[c], exp_rgb[c], exp_t[c]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1; wr_pal = 3; wr_idx = 4; wr_rgb = 12'h123; commit = 1; frame_start = 1;
    tick();
    idle(); wr_en = 1; wr_pal = 3; wr_idx = 4; wr_rgb = 12'h456; commit = 1;
    rd_valid = 2'b11; rd_idx = {4'd12, 4'd12};
    tick();
    idle();
    tests++;
    if (swap_pending !== 1'b1 || rgb_valid !== 2'b11) begin
      fails++;
      $display("[TB] FAIL pre_reset: sp=%b valid=%b, want 1 11", swap_pending, rgb_valid);
    end
    Reset_n = 1'b0;
    #2;
    model_reset();
    tests++;
    if (swap_pending !== 1'b0 || rgb_valid !== 2'b00 || red !== 0 ||
        green !== 0 || blue !== 0 || transparent !== 2'b00) begin
      fails++;
      $display("[TB] FAIL async_reset: sp=%b valid=%b r=%h g=%h b=%h t=%b, want all 0",
               swap_pending, rgb_valid, red, green, blue, transparent);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(); frame_start = 1; tick();
    read1(0, 3, 4);
    tests++;
    if (dut_rgb(0) !== def_tab[4]) begin
      fails++;
      $display("[TB] FAIL reset_front_default: rgb=%h, want %h", dut_rgb(0), def_tab[4]);
    end
  endtask

  initial begin
    test_reset();
    test_default_lookup();
    test_write_commit();
    test_same_cycle_swap();
    test_transparency();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
